// File: rtl/matrix_fill_if.sv
// Operand bus between the word source and the matrix unpacker.
// The source drives the strobes and data; the unpacker returns the registered matrix.
interface matrix_fill_if #(
    parameter int ROWS   = 2,
    parameter int COLS   = 4,
    parameter int ELEM_W = 4
);
    localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                          in_valid;
    logic [ROWS*COLS*ELEM_W-1:0]   A_rows;
    logic                          row_valid;
    logic [COLS*ELEM_W-1:0]        row_data;
    logic [ELEM_W-1:0]             A [0:ROWS-1][0:COLS-1];
    logic                          A_valid;
    logic                          fill_done;
    logic [PTR_W-1:0]              row_ptr;

    modport master (
        output in_valid, A_rows, row_valid, row_data,
        input  A, A_valid, fill_done, row_ptr
    );

    modport slave (
        input  in_valid, A_rows, row_valid, row_data,
        output A, A_valid, fill_done, row_ptr
    );
endinterface

// File: rtl/matrix_fill.sv
// Registered unpacker: full-matrix load or row-at-a-time streaming fill into a ROWS x COLS array.
// One row register per matrix row; the top level only steers data and tracks completion.
module matrix_fill_row #(
    parameter int COLS   = 4,
    parameter int ELEM_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [COLS-1:0][ELEM_W-1:0]  d,
    output logic [COLS-1:0][ELEM_W-1:0]  q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= d;
    end
endmodule

module matrix_fill #(
    parameter int ROWS   = 2,
    parameter int COLS   = 4,
    parameter int ELEM_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    matrix_fill_if.slave  bus
);
    localparam int ROW_W = COLS * ELEM_W;
    localparam int W     = ROWS * ROW_W;
    localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(ROWS - 1);

    logic [ROWS-1:0][COLS-1:0][ELEM_W-1:0] row_q;

    genvar i, j;
    generate
        for (i = 0; i < ROWS; i++) begin : g_row
            localparam logic [PTR_W-1:0] IDX = PTR_W'(i);
            logic                        we;
            logic [COLS-1:0][ELEM_W-1:0] d;

            // A full load overrides any concurrent row write, including its data.
            assign we = bus.in_valid | (bus.row_valid & (bus.row_ptr == IDX));
            assign d  = bus.in_valid ? bus.A_rows[W-1-i*ROW_W -: ROW_W] : bus.row_data;

            matrix_fill_row #(.COLS(COLS), .ELEM_W(ELEM_W)) u_row (
                .clk (clk),
                .rst (rst),
                .we  (we),
                .d   (d),
                .q   (row_q[i])
            );

            // Packed element COLS-1 is the MSB slice, which is column 0.
            for (j = 0; j < COLS; j++) begin : g_col
                assign bus.A[i][j] = row_q[i][COLS-1-j];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.row_ptr   <= '0;
            bus.A_valid   <= 1'b0;
            bus.fill_done <= 1'b0;
        end else if (bus.in_valid) begin
            bus.row_ptr   <= '0;
            bus.A_valid   <= 1'b1;
            bus.fill_done <= 1'b1;
        end else if (bus.row_valid) begin
            if (bus.row_ptr == LAST) begin
                bus.row_ptr   <= '0;
                bus.A_valid   <= 1'b1;
                bus.fill_done <= 1'b1;
            end else begin
                // Starting a new streaming fill makes the held matrix partial.
                if (bus.row_ptr == '0) bus.A_valid <= 1'b0;
                bus.row_ptr   <= bus.row_ptr + PTR_W'(1);
                bus.fill_done <= 1'b0;
            end
        end else begin
            bus.fill_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_matrix_fill.sv
// Directed bench for matrix_fill at the default 2x4x4 geometry.
module tb_matrix_fill;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    matrix_fill_if #(.ROWS(2), .COLS(4), .ELEM_W(4)) bus ();

    matrix_fill #(.ROWS(2), .COLS(4), .ELEM_W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] row_of(input int r);
        return {bus.A[r][0], bus.A[r][1], bus.A[r][2], bus.A[r][3]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.row_valid = 1'b0;
        bus.A_rows    = '0;
        bus.row_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.A_rows   = 32'hFFFF_FFFF;
        step();
        step();
        vectors++;
        if (row_of(0) !== 16'h0000 || row_of(1) !== 16'h0000) begin
            errors++;
            $display("FAIL reset_A: got %h_%h want 0000_0000", row_of(0), row_of(1));
        end
        vectors++;
        if (bus.A_valid !== 1'b0 || bus.fill_done !== 1'b0 || bus.row_ptr !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: valid=%b done=%b ptr=%b want 0 0 0",
                     bus.A_valid, bus.fill_done, bus.row_ptr);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_full_load();
        bus.in_valid = 1'b1;
        bus.A_rows   = 32'h0101_1101;
        step();
        idle_inputs();
        vectors++;
        if (row_of(0) !== 16'h0101 || row_of(1) !== 16'h1101) begin
            errors++;
            $display("FAIL full_load_A: got %h_%h want 0101_1101", row_of(0), row_of(1));
        end
        vectors++;
        if (bus.A_valid !== 1'b1 || bus.fill_done !== 1'b1 || bus.row_ptr !== 1'b0) begin
            errors++;
            $display("FAIL full_load_ctl: valid=%b done=%b ptr=%b want 1 1 0",
                     bus.A_valid, bus.fill_done, bus.row_ptr);
        end
        step();
        vectors++;
        if (bus.fill_done !== 1'b0) begin
            errors++;
            $display("FAIL full_load_pulse: done=%b want 0", bus.fill_done);
        end
    endtask

    task automatic test_row_stream();
        bus.row_valid = 1'b1;
        bus.row_data  = 16'h1234;
        step();
        vectors++;
        if (row_of(0) !== 16'h1234 || row_of(1) !== 16'h1101 || bus.row_ptr !== 1'b1 ||
            bus.A_valid !== 1'b0 || bus.fill_done !== 1'b0) begin
            errors++;
            $display("FAIL stream_row0: A=%h_%h ptr=%b valid=%b done=%b want 1234_1101 1 0 0",
                     row_of(0), row_of(1), bus.row_ptr, bus.A_valid, bus.fill_done);
        end
        bus.row_data = 16'hABCD;
        step();
        idle_inputs();
        vectors++;
        if (row_of(0) !== 16'h1234 || row_of(1) !== 16'hABCD || bus.row_ptr !== 1'b0 ||
            bus.A_valid !== 1'b1 || bus.fill_done !== 1'b1) begin
            errors++;
            $display("FAIL stream_row1: A=%h_%h ptr=%b valid=%b done=%b want 1234_abcd 0 1 1",
                     row_of(0), row_of(1), bus.row_ptr, bus.A_valid, bus.fill_done);
        end
        step();
        vectors++;
        if (bus.fill_done !== 1'b0 || bus.A_valid !== 1'b1) begin
            errors++;
            $display("FAIL stream_after: done=%b valid=%b want 0 1", bus.fill_done, bus.A_valid);
        end
    endtask

    task automatic test_priority();
        // Leave the pointer mid-fill so the load must also rewind it.
        bus.row_valid = 1'b1;
        bus.row_data  = 16'h7777;
        step();
        bus.in_valid = 1'b1;
        bus.A_rows   = 32'h89AB_CDEF;
        bus.row_data = 16'h0000;
        step();
        idle_inputs();
        vectors++;
        if (row_of(0) !== 16'h89AB || row_of(1) !== 16'hCDEF) begin
            errors++;
            $display("FAIL priority_A: got %h_%h want 89ab_cdef", row_of(0), row_of(1));
        end
        vectors++;
        if (bus.row_ptr !== 1'b0 || bus.A_valid !== 1'b1 || bus.fill_done !== 1'b1) begin
            errors++;
            $display("FAIL priority_ctl: ptr=%b valid=%b done=%b want 0 1 1",
                     bus.row_ptr, bus.A_valid, bus.fill_done);
        end
    endtask

    task automatic test_reset_mid_fill();
        bus.row_valid = 1'b1;
        bus.row_data  = 16'h5555;
        step();
        vectors++;
        if (row_of(0) !== 16'h5555 || bus.row_ptr !== 1'b1) begin
            errors++;
            $display("FAIL midfill_pre: A0=%h ptr=%b want 5555 1", row_of(0), bus.row_ptr);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.row_valid = 1'b0;
        vectors++;
        if (row_of(0) !== 16'h0000 || row_of(1) !== 16'h0000 || bus.row_ptr !== 1'b0 ||
            bus.A_valid !== 1'b0) begin
            errors++;
            $display("FAIL midfill_rst: A=%h_%h ptr=%b valid=%b want 0000_0000 0 0",
                     row_of(0), row_of(1), bus.row_ptr, bus.A_valid);
        end
        bus.row_valid = 1'b1;
        bus.row_data  = 16'h2468;
        step();
        idle_inputs();
        vectors++;
        if (row_of(0) !== 16'h2468 || row_of(1) !== 16'h0000 || bus.row_ptr !== 1'b1) begin
            errors++;
            $display("FAIL midfill_restart: A=%h_%h ptr=%b want 2468_0000 1",
                     row_of(0), row_of(1), bus.row_ptr);
        end
    endtask

    task automatic test_hold();
        bus.in_valid = 1'b1;
        bus.A_rows   = 32'h1357_9BDF;
        step();
        idle_inputs();
        for (int k = 0; k < 10; k++) begin
            step();
            vectors++;
            if (row_of(0) !== 16'h1357 || row_of(1) !== 16'h9BDF || bus.A_valid !== 1'b1 ||
                bus.fill_done !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: A=%h_%h valid=%b done=%b want 1357_9bdf 1 0",
                         k, row_of(0), row_of(1), bus.A_valid, bus.fill_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] loads [2];
        logic [15:0] rows [4];
        logic        exp_done [4];
        loads = '{32'hDEAD_BEEF, 32'h0F1E_2D3C};
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.A_rows   = loads[k];
            step();
            vectors++;
            if ({row_of(0), row_of(1)} !== loads[k] || bus.fill_done !== 1'b1) begin
                errors++;
                $display("FAIL b2b_load_%0d: A=%h_%h done=%b want %h 1",
                         k, row_of(0), row_of(1), bus.fill_done, loads[k]);
            end
        end
        bus.in_valid = 1'b0;
        rows     = '{16'hA1A2, 16'hB1B2, 16'hC1C2, 16'hD1D2};
        exp_done = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            bus.row_valid = 1'b1;
            bus.row_data  = rows[k];
            step();
            vectors++;
            if (row_of(k % 2) !== rows[k] || bus.fill_done !== exp_done[k] ||
                bus.A_valid !== exp_done[k] || bus.row_ptr !== ((k % 2 == 0) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL b2b_row_%0d: A%0d=%h done=%b valid=%b ptr=%b want %h %b %b",
                         k, k % 2, row_of(k % 2), bus.fill_done, bus.A_valid, bus.row_ptr,
                         rows[k], exp_done[k], exp_done[k]);
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_full_load();
        test_row_stream();
        test_priority();
        test_reset_mid_fill();
        test_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
